// File: rtl/ual_pkg.sv
// Shared types for the UAL result stage: operation codes, flag positions,
// serial-shifter modes and the control FSM state enum.
package ual_pkg;

  typedef enum logic [2:0] {
    OP_AU   = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_SHL  = 3'd4,
    OP_SHR  = 3'd5,
    OP_ROL  = 3'd6,
    OP_ROR  = 3'd7
  } op_t;

  // Bit 1 selects rotate, bit 0 selects right; matches op[1:0] of the shift ops.
  typedef enum logic [1:0] {
    SM_SHL = 2'b00,
    SM_SHR = 2'b01,
    SM_ROL = 2'b10,
    SM_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  function automatic logic is_shift_op(op_t op);
    return op[2];
  endfunction

  function automatic shift_mode_t op_to_mode(op_t op);
    return shift_mode_t'(op[1:0]);
  endfunction

endpackage

// File: rtl/ual_result_unit_if.sv
// Request/result bundle between operand fetch, the UAL result stage and write-back.
interface ual_result_unit_if #(
  parameter int WIDTH = 8
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  ual_pkg::op_t       op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   au_result;
  logic               au_carry;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [2:0]         flags;

  modport master (
    output in_valid, op, a, b, au_result, au_carry, shamt, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, au_result, au_carry, shamt, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/ual_serial_shifter.sv
// Serial shift/rotate engine: one bit position per cycle. value/carry present the
// result of the step taken at the next edge, so the final step can be captured directly.
module ual_serial_shifter
  import ual_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  input  shift_mode_t        mode,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   value,
  output logic               carry
);

  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  shift_mode_t        mode_q;

  always_comb begin
    value = work;
    carry = 1'b0;
    case (mode_q)
      SM_SHL: begin value = {work[WIDTH-2:0], 1'b0};        carry = work[WIDTH-1]; end
      SM_SHR: begin value = {1'b0, work[WIDTH-1:1]};        carry = work[0];       end
      SM_ROL: begin value = {work[WIDTH-2:0], work[WIDTH-1]}; carry = work[WIDTH-1]; end
      SM_ROR: begin value = {work[0], work[WIDTH-1:1]};     carry = work[0];       end
      default: ;
    endcase
  end

  assign busy = (cnt != '0);
  assign done = (cnt == SHAMT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      cnt    <= '0;
      mode_q <= SM_SHL;
    end else if (start) begin
      work   <= din;
      cnt    <= shamt;
      mode_q <= mode;
    end else if (busy) begin
      work <= value;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/ual_result_unit.sv
// UAL result stage: logic ops and AU pass-through complete in one cycle, shifts and
// rotates go through the serial shifter; result and flags sit in a valid/ready register.
//
// state    | meaning
// ST_IDLE  | accepts requests when the output register is free or being consumed
// ST_SHIFT | serial shifter busy, in_ready held low
module ual_result_unit
  import ual_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst_n,
  ual_result_unit_if.slave bus
);

  state_t             state;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         flags_q;
  logic               out_valid_q;
  logic [SHAMT_W-1:0] shamt;
  shift_mode_t        mode;
  logic [WIDTH-1:0]   imm_value, sh_value, load_value;
  logic               imm_carry, sh_carry, load_carry;
  logic               accept, start, load_imm, load, sh_busy, sh_done;

  assign shamt        = bus.shamt;
  assign mode         = op_to_mode(bus.op);
  assign bus.in_ready = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start        = accept && is_shift_op(bus.op) && (shamt != '0);
  assign load_imm     = accept && !start;
  assign load         = load_imm || sh_done;

  // Shift ops reaching this path have a zero amount: pass a through with C=0.
  always_comb begin
    imm_value = bus.a;
    imm_carry = 1'b0;
    case (bus.op)
      OP_AU:   begin imm_value = bus.au_result; imm_carry = bus.au_carry; end
      OP_NAND: imm_value = ~(bus.a & bus.b);
      OP_OR:   imm_value = bus.a | bus.b;
      OP_XOR:  imm_value = bus.a ^ bus.b;
      default: ;
    endcase
  end

  assign load_value = sh_done ? sh_value : imm_value;
  assign load_carry = sh_done ? sh_carry : imm_carry;

  ual_serial_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .shamt (shamt),
    .din   (bus.a),
    .mode  (mode),
    .busy  (sh_busy),
    .done  (sh_done),
    .value (sh_value),
    .carry (sh_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_SHIFT;
        ST_SHIFT: if (sh_done || !sh_busy) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (load) begin
        result_q        <= load_value;
        flags_q[FLAG_N] <= load_value[WIDTH-1];
        flags_q[FLAG_Z] <= (load_value == '0);
        flags_q[FLAG_C] <= load_carry;
        out_valid_q     <= 1'b1;
      end else if (start || bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_ual_result_unit.sv
// Self-checking bench for ual_result_unit: directed vector table, hand-written
// backpressure/reset sequences and randomized traffic against an arithmetic model.
module tb_ual_result_unit;
  import ual_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ual_result_unit_if #(.WIDTH(W)) bus();

  ual_result_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] au;
    logic       auc;
    logic [2:0] s;
    logic [7:0] er;
    logic [2:0] ef;
  } vec_t;

  vec_t vecs[12];
  logic [10:0] expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {result, N, Z, C} straight from the operation rules.
  function automatic logic [10:0] model(input int op, input int a, input int b,
                                        input int au, input int auc, input int s);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = au; c = auc; end
      1: r = ~(a & b) & 255;
      2: r = a | b;
      3: r = a ^ b;
      4: begin r = (a << s) & 255; c = (s > 0) ? ((a >> (8 - s)) & 1) : 0; end
      5: begin r = a >> s;         c = (s > 0) ? ((a >> (s - 1)) & 1) : 0; end
      6: begin r = ((a << s) | (a >> (8 - s))) & 255; c = (s > 0) ? (r & 1) : 0; end
      default: begin r = ((a >> s) | (a << (8 - s))) & 255; c = (s > 0) ? ((r >> 7) & 1) : 0; end
    endcase
    return {r[7:0], r[7], (r == 0), c[0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, cons, seen;
    logic [10:0] exp_now;

    vecs[0]  = '{3'd0, 8'h00, 8'h00, 8'h00, 1'b1, 3'd0, 8'h00, 3'b011};
    vecs[1]  = '{3'd1, 8'hF0, 8'hCC, 8'h00, 1'b0, 3'd0, 8'h3F, 3'b000};
    vecs[2]  = '{3'd2, 8'h80, 8'h01, 8'h00, 1'b0, 3'd0, 8'h81, 3'b100};
    vecs[3]  = '{3'd3, 8'h5A, 8'h5A, 8'h00, 1'b1, 3'd0, 8'h00, 3'b010};
    vecs[4]  = '{3'd0, 8'h00, 8'h00, 8'h9C, 1'b0, 3'd0, 8'h9C, 3'b100};
    vecs[5]  = '{3'd4, 8'h81, 8'h00, 8'h00, 1'b0, 3'd0, 8'h81, 3'b100};
    vecs[6]  = '{3'd7, 8'h01, 8'h00, 8'h00, 1'b0, 3'd1, 8'h80, 3'b101};
    vecs[7]  = '{3'd4, 8'h81, 8'h00, 8'h00, 1'b0, 3'd3, 8'h08, 3'b000};
    vecs[8]  = '{3'd5, 8'h81, 8'h00, 8'h00, 1'b0, 3'd1, 8'h40, 3'b001};
    vecs[9]  = '{3'd6, 8'h80, 8'h00, 8'h00, 1'b0, 3'd1, 8'h01, 3'b001};
    vecs[10] = '{3'd4, 8'h01, 8'h00, 8'h00, 1'b0, 3'd7, 8'h80, 3'b100};
    vecs[11] = '{3'd5, 8'h80, 8'h00, 8'h00, 1'b0, 3'd7, 8'h01, 3'b000};

    bus.in_valid  = 1'b0;
    bus.op        = OP_AU;
    bus.a         = '0;
    bus.b         = '0;
    bus.au_result = '0;
    bus.au_carry  = 1'b0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_result", bus.result, 8'h00);
    check("reset_flags", bus.flags, 3'b000);
    check("reset_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 12; i++) begin
      bus.op        = op_t'(vecs[i].op);
      bus.a         = vecs[i].a;
      bus.b         = vecs[i].b;
      bus.au_result = vecs[i].au;
      bus.au_carry  = vecs[i].auc;
      bus.shamt     = vecs[i].s;
      bus.in_valid  = 1'b1;
      #1;
      check("vec_in_ready", bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      if (vecs[i].op >= 3'd4 && vecs[i].s != 3'd0) begin
        for (int k = 0; k < int'(vecs[i].s); k++) begin
          check("vec_busy_in_ready", bus.in_ready, 0);
          check("vec_busy_out_valid", bus.out_valid, 0);
          tick();
        end
      end
      check("vec_out_valid", bus.out_valid, 1);
      check("vec_result", bus.result, vecs[i].er);
      check("vec_flags", bus.flags, vecs[i].ef);
      tick();
    end

    // Backpressure: second XOR must wait until the first result is consumed.
    bus.out_ready = 1'b0;
    bus.op        = OP_XOR;
    bus.a         = 8'hFF;
    bus.b         = 8'h0F;
    bus.in_valid  = 1'b1;
    #1;
    tick();
    bus.a = 8'hAA;
    bus.b = 8'hAA;
    #1;
    check("bp_first_valid", bus.out_valid, 1);
    check("bp_first_result", bus.result, 8'hF0);
    check("bp_first_flags", bus.flags, 3'b100);
    check("bp_in_ready_low", bus.in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_result", bus.result, 8'hF0);
      check("bp_hold_flags", bus.flags, 3'b100);
      check("bp_hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_valid", bus.out_valid, 1);
    check("bp_second_result", bus.result, 8'h00);
    check("bp_second_flags", bus.flags, 3'b010);
    tick();
    check("bp_drained", bus.out_valid, 0);

    // Reset in the third SHIFT cycle of a 7-position rotate.
    bus.op       = OP_ROL;
    bus.a        = 8'h35;
    bus.shamt    = 3'd7;
    bus.in_valid = 1'b1;
    #1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check("abort_busy_before_reset", bus.in_ready, 0);
    rst_n = 1'b0;
    #2;
    check("abort_out_valid_in_reset", bus.out_valid, 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    check("abort_idle_in_ready", bus.in_ready, 1);

    // Randomized traffic against the model, results checked as they are consumed.
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.op        = op_t'($urandom_range(0, 7));
      bus.a         = 8'($urandom_range(0, 255));
      bus.b         = 8'($urandom_range(0, 255));
      bus.au_result = 8'($urandom_range(0, 255));
      bus.au_carry  = 1'($urandom_range(0, 1));
      bus.shamt     = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc  = bus.in_valid && bus.in_ready;
      cons = bus.out_valid && bus.out_ready;
      exp_now = model(int'(bus.op), int'(bus.a), int'(bus.b), int'(bus.au_result),
                      int'(bus.au_carry), int'(bus.shamt));
      if (cons) begin
        if (expq.size() == 0) check("rand_unexpected_result", 1, 0);
        else check("rand_result_flags", {bus.result, bus.flags}, expq.pop_front());
      end
      tick();
      if (acc) expq.push_back(exp_now);
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && expq.size() > 0; k++) begin
      #1;
      if (bus.out_valid) check("drain_result_flags", {bus.result, bus.flags}, expq.pop_front());
      tick();
    end
    check("drain_queue_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
